// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: FSM states and access owner.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_WAIT,
        ARB_DONE
    } arb_state_e;

    typedef enum logic {
        OWNER_CORE,
        OWNER_LOAD
    } arb_owner_e;

    localparam int unsigned LatW = 3;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between core and loader; core wins unless the optional
// starvation counter (MEM_ARB_FAIRNESS_EN) forces a loader grant.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
`ifdef MEM_ARB_FAIRNESS_EN
    input  logic       clk,
    input  logic       rst_n,
    input  logic       idle,
`endif
    input  logic       core_req,
    input  logic       load_req,
    output logic       grant_valid,
    output arb_owner_e owner
);

    assign grant_valid = core_req | load_req;

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            force_load;

    assign force_load = load_req && (cnt_q >= CntW'(STARVE_MAX));
    assign owner      = (core_req && !force_load) ? OWNER_CORE : OWNER_LOAD;

    // Counts only core grants taken while the loader was waiting.
    always_comb begin
        cnt_d = cnt_q;
        if (idle) begin
            if (!load_req) begin
                cnt_d = '0;
            end else if (owner == OWNER_LOAD) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign owner = core_req ? OWNER_CORE : OWNER_LOAD;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester data-memory port arbiter with issue/wait/ack FSM.
// Optional loader fairness enabled by defining MEM_ARB_FAIRNESS_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned AW         = 8,
    parameter int unsigned DW         = 8,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_ack,
    output logic          core_stall,
    input  logic          load_req,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_wdata,
    output logic [DW-1:0] load_rdata,
    output logic          load_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [LatW-1:0] LatInit = LatW'(RD_LAT - 1);

    arb_state_e      state_q, state_d;
    arb_owner_e      owner_q, owner_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [LatW-1:0] lat_q, lat_d;
    logic [DW-1:0]   core_rdata_q, core_rdata_d;
    logic [DW-1:0]   load_rdata_q, load_rdata_d;

    logic            grant_valid;
    arb_owner_e      pick_owner;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
`ifdef MEM_ARB_FAIRNESS_EN
        .clk         (clk),
        .rst_n       (rst_n),
        .idle        (state_q == ARB_IDLE),
`endif
        .core_req    (core_req),
        .load_req    (load_req),
        .grant_valid (grant_valid),
        .owner       (pick_owner)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        lat_d        = lat_q;
        core_rdata_d = core_rdata_q;
        load_rdata_d = load_rdata_q;
        case (state_q)
            ARB_IDLE: begin
                // Request inputs are only looked at here; later changes are ignored.
                if (grant_valid) begin
                    owner_d = pick_owner;
                    if (pick_owner == OWNER_CORE) begin
                        we_d    = core_we;
                        addr_d  = core_addr;
                        wdata_d = core_wdata;
                    end else begin
                        we_d    = load_we;
                        addr_d  = load_addr;
                        wdata_d = load_wdata;
                    end
                    state_d = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                if (we_q) begin
                    state_d = ARB_DONE;
                end else begin
                    lat_d   = LatInit;
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (lat_q == '0) begin
                    if (owner_q == OWNER_CORE) begin
                        core_rdata_d = mem_rdata;
                    end else begin
                        load_rdata_d = mem_rdata;
                    end
                    state_d = ARB_DONE;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWNER_CORE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            lat_q        <= '0;
            core_rdata_q <= '0;
            load_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            lat_q        <= lat_d;
            core_rdata_q <= core_rdata_d;
            load_rdata_q <= load_rdata_d;
        end
    end

    assign mem_en     = (state_q == ARB_ACCESS);
    assign mem_we     = mem_en & we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign core_ack   = (state_q == ARB_DONE) && (owner_q == OWNER_CORE);
    assign load_ack   = (state_q == ARB_DONE) && (owner_q == OWNER_LOAD);
    assign core_stall = core_req & ~core_ack;
    assign core_rdata = core_rdata_q;
    assign load_rdata = load_rdata_q;
    assign busy       = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (RD_LAT=3, STARVE_MAX=4); memory returns addr ^ 0x1C.
module tb_mem_port_arbiter;

    localparam int unsigned AW     = 8;
    localparam int unsigned DW     = 8;
    localparam int unsigned RD_LAT = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          core_req, core_we, load_req, load_we;
    logic [AW-1:0] core_addr, load_addr, mem_addr;
    logic [DW-1:0] core_wdata, load_wdata, mem_wdata, mem_rdata;
    logic [DW-1:0] core_rdata, load_rdata;
    logic          core_ack, core_stall, load_ack, mem_en, mem_we, busy;

    int checks = 0;
    int fails  = 0;

    mem_port_arbiter #(
        .AW         (AW),
        .DW         (DW),
        .RD_LAT     (RD_LAT),
        .STARVE_MAX (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_ack   (core_ack),
        .core_stall (core_stall),
        .load_req   (load_req),
        .load_we    (load_we),
        .load_addr  (load_addr),
        .load_wdata (load_wdata),
        .load_rdata (load_rdata),
        .load_ack   (load_ack),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Read data appears exactly RD_LAT cycles after the mem_en cycle; 0xEE elsewhere.
    logic [DW-1:0] pipe [RD_LAT];
    always @(posedge clk) begin
        pipe[0] <= (mem_en && !mem_we) ? (mem_addr ^ 8'h1C) : 8'hEE;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[RD_LAT-1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until the selected ack is seen; n = cycles stepped, -1 if the budget runs out.
    task automatic wait_ack(input bit is_core, input int budget, output int n);
        n = 0;
        while (!(is_core ? core_ack : load_ack) && n < budget) begin
            step();
            n++;
        end
        if (!(is_core ? core_ack : load_ack)) n = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        load_req = 0; load_we = 0; load_addr = '0; load_wdata = '0;
        for (int i = 0; i < RD_LAT + 2; i++) pipe[i % RD_LAT] = 8'hEE;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (mem_en !== 1'b0) begin fails++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
        checks++; if (mem_we !== 1'b0) begin fails++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        checks++; if (mem_addr !== 8'h00) begin fails++; $display("FAIL rst_mem_addr: got %h want 00", mem_addr); end
        checks++; if ({core_ack, load_ack, core_stall} !== 3'b000) begin
            fails++; $display("FAIL rst_acks: got %b want 000", {core_ack, load_ack, core_stall});
        end
        checks++; if ({core_rdata, load_rdata} !== 16'h0000) begin
            fails++; $display("FAIL rst_rdata: got %h want 0000", {core_rdata, load_rdata});
        end
    endtask

    task automatic test_core_write();
        core_req = 1; core_we = 1; core_addr = 8'h10; core_wdata = 8'hA5;
        #1;
        checks++; if (core_stall !== 1'b1) begin fails++; $display("FAIL wr_stall_c0: got %b want 1", core_stall); end
        step();
        checks++; if ({mem_en, mem_we} !== 2'b11) begin
            fails++; $display("FAIL wr_mem_c1: got %b want 11", {mem_en, mem_we});
        end
        checks++; if ({mem_addr, mem_wdata} !== 16'h10A5) begin
            fails++; $display("FAIL wr_addr_data: got %h want 10a5", {mem_addr, mem_wdata});
        end
        checks++; if ({core_ack, core_stall} !== 2'b01) begin
            fails++; $display("FAIL wr_c1_ack_stall: got %b want 01", {core_ack, core_stall});
        end
        step();
        checks++; if ({core_ack, core_stall, mem_en} !== 3'b100) begin
            fails++; $display("FAIL wr_c2_ack: got %b want 100", {core_ack, core_stall, mem_en});
        end
        core_req = 0;
        step();
        checks++; if ({busy, core_ack} !== 2'b00) begin
            fails++; $display("FAIL wr_c3_idle: got %b want 00", {busy, core_ack});
        end
    endtask

    task automatic test_core_read();
        int n;
        core_req = 1; core_we = 0; core_addr = 8'h20;
        #1;
        step();
        checks++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 8'h20}) begin
            fails++; $display("FAIL rd_issue: got %b %h want 10 20", {mem_en, mem_we}, mem_addr);
        end
        wait_ack(1'b1, 10, n);
        checks++; if (n + 1 !== 5) begin fails++; $display("FAIL rd_latency: got cycle %0d want 5", n + 1); end
        checks++; if (core_rdata !== 8'h3C) begin fails++; $display("FAIL rd_data: got %h want 3c", core_rdata); end
        checks++; if (load_rdata !== 8'h00) begin fails++; $display("FAIL rd_load_untouched: got %h want 00", load_rdata); end
        core_req = 0;
        step();
        step();
        checks++; if (core_rdata !== 8'h3C) begin fails++; $display("FAIL rd_hold: got %h want 3c", core_rdata); end
    endtask

    task automatic test_priority();
        core_req = 1; core_we = 1; core_addr = 8'h30; core_wdata = 8'h11;
        load_req = 1; load_we = 1; load_addr = 8'h40; load_wdata = 8'h22;
        #1;
        step();
        checks++; if ({mem_en, mem_addr} !== {1'b1, 8'h30}) begin
            fails++; $display("FAIL pri_core_first: got %b %h want 1 30", mem_en, mem_addr);
        end
        step();
        checks++; if ({core_ack, load_ack} !== 2'b10) begin
            fails++; $display("FAIL pri_core_ack: got %b want 10", {core_ack, load_ack});
        end
        core_req = 0;
        step();
        checks++; if ({busy, mem_en} !== 2'b00) begin
            fails++; $display("FAIL pri_idle_gap: got %b want 00", {busy, mem_en});
        end
        step();
        checks++; if ({mem_en, mem_addr, mem_wdata} !== {1'b1, 8'h40, 8'h22}) begin
            fails++; $display("FAIL pri_load_issue: got %b %h %h want 1 40 22", mem_en, mem_addr, mem_wdata);
        end
        step();
        checks++; if ({core_ack, load_ack} !== 2'b01) begin
            fails++; $display("FAIL pri_load_ack: got %b want 01", {core_ack, load_ack});
        end
        load_req = 0;
        step();
    endtask

    task automatic test_fairness();
        logic [7:0] got [6];
        logic [7:0] want [6];
        int g = 0;
        int cyc = 0;
`ifdef MEM_ARB_FAIRNESS_EN
        want = '{8'h50, 8'h50, 8'h50, 8'h50, 8'h60, 8'h50};
`else
        want = '{8'h50, 8'h50, 8'h50, 8'h50, 8'h50, 8'h50};
`endif
        for (int i = 0; i < 6; i++) got[i] = 8'hFF;
        core_req = 1; core_we = 1; core_addr = 8'h50; core_wdata = 8'h01;
        load_req = 1; load_we = 1; load_addr = 8'h60; load_wdata = 8'h02;
        #1;
        while (g < 6 && cyc < 60) begin
            step();
            cyc++;
            if (mem_en) begin
                got[g] = mem_addr;
                g++;
            end
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== want[i]) begin
                fails++; $display("FAIL fair_grant%0d: got addr %h want %h", i, got[i], want[i]);
            end
        end
        core_req = 0; load_req = 0;
        repeat (6) step();
    endtask

    task automatic test_reset_mid_access();
        int n;
        core_req = 1; core_we = 0; core_addr = 8'h20;
        #1;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, mem_en, core_ack, load_ack} !== 4'b0000) begin
            fails++; $display("FAIL rstmid_outputs: got %b want 0000", {busy, mem_en, core_ack, load_ack});
        end
        checks++; if (core_rdata !== 8'h00) begin fails++; $display("FAIL rstmid_rdata: got %h want 00", core_rdata); end
        core_req = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        core_req = 1; core_we = 0; core_addr = 8'h40;
        #1;
        wait_ack(1'b1, 10, n);
        checks++; if (n !== 5) begin fails++; $display("FAIL rstmid_fresh_lat: got cycle %0d want 5", n); end
        checks++; if (core_rdata !== 8'h5C) begin fails++; $display("FAIL rstmid_fresh_data: got %h want 5c", core_rdata); end
        core_req = 0;
        step();
    endtask

    task automatic test_load_then_core();
        int n;
        load_req = 1; load_we = 0; load_addr = 8'h30;
        #1;
        step();
        step();
        core_req = 1; core_we = 0; core_addr = 8'h10;
        wait_ack(1'b0, 10, n);
        checks++; if (n !== 3) begin fails++; $display("FAIL lc_load_lat: got %0d more cycles want 3", n); end
        checks++; if ({load_ack, core_ack, core_stall} !== 3'b101) begin
            fails++; $display("FAIL lc_load_ack: got %b want 101", {load_ack, core_ack, core_stall});
        end
        checks++; if ({load_rdata, core_rdata} !== 16'h2C5C) begin
            fails++; $display("FAIL lc_rdata: got %h want 2c5c", {load_rdata, core_rdata});
        end
        load_req = 0;
        step();
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL lc_idle_gap: got %b want 0", busy); end
        step();
        checks++; if ({mem_en, mem_addr} !== {1'b1, 8'h10}) begin
            fails++; $display("FAIL lc_core_issue: got %b %h want 1 10", mem_en, mem_addr);
        end
        wait_ack(1'b1, 10, n);
        checks++; if (n !== 4) begin fails++; $display("FAIL lc_core_lat: got %0d more cycles want 4", n); end
        checks++; if ({core_rdata, load_rdata} !== 16'h0C2C) begin
            fails++; $display("FAIL lc_core_data: got %h want 0c2c", {core_rdata, load_rdata});
        end
        core_req = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_core_write();
        test_core_read();
        test_priority();
        test_fairness();
        test_reset_mid_access();
        test_load_then_core();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
